mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-ported synchronous SRAM between the core's instruction-fetch port and data port. It sits between `core` (imem_*/dmem_* side) and the unified memory macro. It grants at most one access per cycle, routes read data back to the owner one cycle later, and bounds instruction-fetch starvation under sustained data traffic.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_starve_ctr.sv | 32 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data SRAM arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned STARVE_MAX_LIMIT = 15;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_I,
    RESP_D
  } resp_owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive D grants while I waits; force_i hands the next slot to I.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  output logic force_i
);

  localparam int unsigned CW = $clog2(STARVE_MAX_LIMIT + 1);
  localparam logic [CW-1:0] MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt && (starve_cnt != MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_i = (starve_cnt == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-ported SRAM.
// Define MEM_ARBITER_PERF_EN to add the perf_conflict counter port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [CNT_W-1:0]    perf_conflict
`endif
);

  if (STARVE_MAX < 1 || STARVE_MAX > STARVE_MAX_LIMIT) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be within 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("mem_arbiter: CNT_W must be at least 1");
  end

  logic        force_i;
  resp_owner_e state, state_next;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_req  (i_req),
    .i_gnt  (i_gnt),
    .d_gnt  (d_gnt),
    .force_i(force_i)
  );

  // Grants are forced low during reset so nothing reaches the SRAM.
  always_comb begin
    i_gnt = !rst && i_req && (!d_req || force_i);
    d_gnt = !rst && d_req && !i_gnt;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (i_gnt) begin
      mem_en   = 1'b1;
      mem_be   = '1;
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESP_NONE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = RESP_NONE;
    if (i_gnt)               state_next = RESP_I;
    else if (d_gnt && !d_we) state_next = RESP_D;
  end

  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    unique case (state)
      RESP_I: begin
        i_rvalid = 1'b1;
        i_rdata  = mem_rdata;
      end
      RESP_D: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
      default: ;
    endcase
  end

`ifdef MEM_ARBITER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 perf_conflict <= '0;
    else if (i_req && d_req) perf_conflict <= perf_conflict + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter against a behavioural SRAM and arbitration model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int SM = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [BW-1:0] d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef MEM_ARBITER_PERF_EN
  logic [CW-1:0] perf_conflict;
`endif

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARBITER_PERF_EN
    , .perf_conflict(perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Reference memory contents and the environment SRAM seeded from it.
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] sram [64];
  logic          init_go = 1'b0;

  always @(posedge clk) begin
    if (init_go) begin
      for (int k = 0; k < 64; k++) sram[k] <= ref_mem[k];
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) sram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr[7:2]];
      end
    end
  end

  typedef struct {
    bit            is_d;
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  resp_t q[$];
  int checks = 0, failures = 0;
  int cyc = 0;
  int wait_cnt = 0;
  int conflicts = 0;

  always @(negedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: each cycle the response outputs must match the scoreboard head.
  initial begin
    resp_t r;
    logic [2*DW+1:0] e;
    forever begin
      @(negedge clk);
      #2;
      e = '0;
      while (q.size() > 0 && q[0].due < cyc) begin
        r = q.pop_front();
        chk("stale_resp", 128'(r.due), 128'(cyc));
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        if (r.is_d) e = {1'b0, {DW{1'b0}}, 1'b1, r.data};
        else        e = {1'b1, r.data, 1'b0, {DW{1'b0}}};
      end
      chk("resp", 128'({i_rvalid, i_rdata, d_rvalid, d_rdata}), 128'(e));
    end
  end

  // One bus cycle: drive requests, check grants and SRAM mux against the model,
  // and schedule the expected read response.
  task automatic bus_cycle(input bit ir, input logic [AW-1:0] ia,
                           input bit dr, input bit dw, input logic [BW-1:0] dbe,
                           input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                           output bit ig, output bit dg);
    logic [69:0] em;
    resp_t r;
    @(negedge clk);
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_be = dbe; d_addr = da; d_wdata = dwd;
    #1;
    ig = ir && (!dr || wait_cnt == SM);
    dg = dr && !ig;
    chk("grants", 128'({i_gnt, d_gnt}), 128'({ig, dg}));
    if (ig)      em = {1'b1, 1'b0, {BW{1'b1}}, ia, {DW{1'b0}}};
    else if (dg) em = {1'b1, dw, dbe, da, dwd};
    else         em = '0;
    chk("mem_bus", 128'({mem_en, mem_we, mem_be, mem_addr, mem_wdata}), 128'(em));
    if (ig) begin
      r.is_d = 1'b0; r.data = ref_mem[ia[7:2]]; r.due = cyc + 1; q.push_back(r);
    end else if (dg && !dw) begin
      r.is_d = 1'b1; r.data = ref_mem[da[7:2]]; r.due = cyc + 1; q.push_back(r);
    end else if (dg && dw) begin
      for (int b = 0; b < BW; b++)
        if (dbe[b]) ref_mem[da[7:2]][8*b +: 8] = dwd[8*b +: 8];
    end
    wait_cnt = (ir && !ig) ? wait_cnt + 1 : 0;
    if (ir && dr) conflicts++;
  endtask

  task automatic idle(input int n);
    bit ig, dg;
    for (int k = 0; k < n; k++) bus_cycle(0, '0, 0, 0, '0, '0, '0, ig, dg);
  endtask

  // Hold reset with both requests asserted and confirm every output is quiet.
  task automatic reset_hold(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      #1;
      chk("rst_outputs", 128'({i_gnt, d_gnt, i_rvalid, i_rdata, d_rvalid, d_rdata,
                               mem_en, mem_we, mem_be, mem_addr, mem_wdata}), '0);
`ifdef MEM_ARBITER_PERF_EN
      chk("rst_perf", 128'(perf_conflict), '0);
`endif
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    rst = 1'b0;
    wait_cnt = 0;
    conflicts = 0;
  endtask

  task automatic random_phase(input int n, input int ip, input int dp);
    bit ip_pend = 0, dp_pend = 0, ig, dg;
    logic [AW-1:0] ia = '0, da = '0;
    logic [DW-1:0] wd = '0;
    logic [BW-1:0] be = '0;
    bit we = 0;
    for (int k = 0; k < n; k++) begin
      if (!ip_pend && $urandom_range(0, 99) < ip) begin
        ip_pend = 1; ia = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!dp_pend && $urandom_range(0, 99) < dp) begin
        dp_pend = 1; da = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
        we = 1'($urandom_range(0, 1)); wd = $urandom;
        be = BW'($urandom_range(1, (1 << BW) - 1));
      end
      bus_cycle(ip_pend, ia, dp_pend, we, be, da, wd, ig, dg);
      if (ig) ip_pend = 0;
      if (dg) dp_pend = 0;
    end
  endtask

  initial begin
    bit ig, dg;
    int dcount;
    for (int k = 0; k < 64; k++) ref_mem[k] = $urandom;
    ref_mem[4]  = 32'hDEADBEEF;
    ref_mem[16] = 32'hAABBCCDD;
    @(negedge clk);
    init_go = 1'b1;
    @(negedge clk);
    init_go = 1'b0;
    reset_hold(3);

    // Lone fetch, then a conflict where D wins and I follows.
    bus_cycle(1, 32'h10, 0, 0, '0, '0, '0, ig, dg);
    bus_cycle(1, 32'h14, 1, 0, 4'hF, 32'h20, '0, ig, dg);
    bus_cycle(1, 32'h14, 0, 0, '0, '0, '0, ig, dg);

    // Sustained D traffic: I must win exactly on the (SM+1)th cycle.
    dcount = 0;
    for (int k = 0; k < SM + 1; k++) begin
      bus_cycle(1, 32'h18, 1, 0, 4'hF, (k % 2) ? 32'h24 : 32'h28, '0, ig, dg);
      if (dg) dcount++;
    end
    chk("starve_d_count", 128'(dcount), 128'(SM));
    chk("starve_i_last", 128'(i_gnt), 128'(1));
    bus_cycle(0, '0, 1, 0, 4'hF, 32'h2C, '0, ig, dg);

    // Partial write then read back of the merged word.
    bus_cycle(0, '0, 1, 1, 4'b0011, 32'h40, 32'h12345678, ig, dg);
    bus_cycle(0, '0, 1, 0, 4'hF, 32'h40, '0, ig, dg);
    idle(1);

    random_phase(400, 60, 95);
    random_phase(400, 50, 50);

    // Reset while a fetch is in flight: its response must never appear.
    idle(1);
    bus_cycle(1, 32'h30, 0, 0, '0, '0, '0, ig, dg);
    rst = 1'b1;
    q.delete();
    reset_hold(2);
    idle(3);

    random_phase(200, 70, 70);
    idle(2);
    chk("scoreboard_drained", 128'(q.size()), '0);
`ifdef MEM_ARBITER_PERF_EN
    chk("perf_conflict", 128'(perf_conflict), 128'(CW'(conflicts)));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
